// File: rtl/core_mdu.sv
// RISC-V M-extension multiply/divide unit: iterative radix-2 shift-add multiplier and
// restoring divider behind a single-request / single-response handshake.
module core_mdu #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned RFIDX_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_funct3,
    input  logic               req_word,
    input  logic [XLEN-1:0]    req_rs1,
    input  logic [XLEN-1:0]    req_rs2,
    input  logic [RFIDX_W-1:0] req_rsd_idx,
    input  logic               flush,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [XLEN-1:0]    resp_data,
    output logic [RFIDX_W-1:0] resp_rsd_idx,
    output logic               busy
);
    localparam int unsigned DW    = 2 * XLEN;
    localparam int unsigned CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nx;

    logic [2:0]         f3_q;
    logic               word_q;
    logic               fast_q;
    logic               neg_q;
    logic [RFIDX_W-1:0] rsd_q;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   n_q;
    logic [XLEN-1:0]    sh_a;
    logic [DW-1:0]      sh_b;
    logic [DW-1:0]      acc;

    logic               accept;
    logic               iterate;
    logic               word_eff, is_div, sgn_a, sgn_b, neg_a, neg_b, div0, ovf;
    logic [XLEN-1:0]    val_a, val_b, mag_a, mag_b, min_neg, fast_val;
    logic [XLEN:0]      rem_sh;
    logic [XLEN-1:0]    rem_sub;
    logic               rem_ge;
    logic [DW-1:0]      prod;
    logic [XLEN-1:0]    qr_mag, qr_res, full, result;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // Request decode: operand selection, signedness, magnitudes and fast-path detection
    always_comb begin
        word_eff = req_word && (XLEN == 64);
        is_div   = req_funct3[2];
        sgn_a    = (req_funct3 == 3'b001) || (req_funct3 == 3'b010) || (is_div && !req_funct3[0]);
        sgn_b    = (req_funct3 == 3'b001) || (is_div && !req_funct3[0]);
        val_a    = req_rs1;
        val_b    = req_rs2;
        min_neg  = {1'b1, {(XLEN-1){1'b0}}};
        if (word_eff) begin
            val_a   = sgn_a ? sext32(req_rs1[31:0]) : XLEN'(req_rs1[31:0]);
            val_b   = sgn_b ? sext32(req_rs2[31:0]) : XLEN'(req_rs2[31:0]);
            min_neg = sext32(32'h8000_0000);
        end
        neg_a = sgn_a && val_a[XLEN-1];
        neg_b = sgn_b && val_b[XLEN-1];
        mag_a = neg_a ? (~val_a + XLEN'(1)) : val_a;
        mag_b = neg_b ? (~val_b + XLEN'(1)) : val_b;
        div0  = is_div && (val_b == '0);
        ovf   = is_div && sgn_a && (val_a == min_neg) && (val_b == '1);
        fast_val = '0;
        if (div0) begin
            fast_val = req_funct3[1] ? val_a : '1;
        end else if (ovf) begin
            fast_val = req_funct3[1] ? '0 : val_a;
        end
    end

    // Iteration step and final sign fix / result selection
    always_comb begin
        rem_sh  = {acc[XLEN-1:0], sh_a[XLEN-1]};
        rem_ge  = (rem_sh >= {1'b0, sh_b[XLEN-1:0]});
        rem_sub = rem_sh[XLEN-1:0] - sh_b[XLEN-1:0];
        prod    = neg_q ? (~acc + DW'(1)) : acc;
        qr_mag  = f3_q[1] ? acc[XLEN-1:0] : sh_a;
        qr_res  = neg_q ? (~qr_mag + XLEN'(1)) : qr_mag;
        if (fast_q) begin
            full = acc[XLEN-1:0];
        end else if (f3_q[2]) begin
            full = qr_res;
        end else if (f3_q[1:0] == 2'b00) begin
            full = prod[XLEN-1:0];
        end else begin
            full = prod[DW-1:XLEN];
        end
        result = word_q ? sext32(full[31:0]) : full;
    end

    assign accept  = (state == IDLE) && req_valid && !flush;
    assign iterate = (state == BUSY) && !fast_q && (cnt != n_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req_valid && !flush) state_nx = BUSY;
            BUSY: begin
                if (flush) begin
                    state_nx = IDLE;
                end else if (fast_q || (cnt == n_q)) begin
                    state_nx = DONE;
                end
            end
            DONE: if (flush || resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture and one multiply/divide step per BUSY cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q   <= '0;
            word_q <= 1'b0;
            fast_q <= 1'b0;
            neg_q  <= 1'b0;
            rsd_q  <= '0;
            cnt    <= '0;
            n_q    <= '0;
            sh_a   <= '0;
            sh_b   <= '0;
            acc    <= '0;
        end else if (accept) begin
            f3_q   <= req_funct3;
            word_q <= word_eff;
            fast_q <= div0 || ovf;
            neg_q  <= (is_div && req_funct3[1]) ? neg_a : (neg_a ^ neg_b);
            rsd_q  <= req_rsd_idx;
            cnt    <= '0;
            n_q    <= word_eff ? CNT_W'(32) : CNT_W'(XLEN);
            sh_a   <= (is_div && word_eff) ? (mag_a << (XLEN - 32)) : mag_a;
            sh_b   <= DW'(mag_b);
            acc    <= DW'(fast_val);
        end else if (iterate) begin
            cnt <= cnt + CNT_W'(1);
            if (f3_q[2]) begin
                acc  <= DW'(rem_ge ? rem_sub : rem_sh[XLEN-1:0]);
                sh_a <= {sh_a[XLEN-2:0], rem_ge};
            end else begin
                if (sh_a[0]) begin
                    acc <= acc + sh_b;
                end
                sh_b <= sh_b << 1;
                sh_a <= sh_a >> 1;
            end
        end
    end

    // Registered handshake outputs follow the next state; result captured on DONE entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            busy         <= 1'b0;
            resp_data    <= '0;
            resp_rsd_idx <= '0;
        end else begin
            req_ready  <= (state_nx == IDLE);
            resp_valid <= (state_nx == DONE);
            busy       <= (state_nx != IDLE);
            if ((state == BUSY) && (state_nx == DONE)) begin
                resp_data    <= result;
                resp_rsd_idx <= rsd_q;
            end
        end
    end

endmodule

// File: doc/core_mdu.md
CORE_MDU -- requirements
Module: core_mdu

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the operand and result width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter RFIDX_W, default 5, giving the destination-register index width.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  block can accept a request; high only in IDLE.
REQ-007 req_funct3  in  3  RV M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 req_word  in  1  W-variant (MULW/DIVW/DIVUW/REMW/REMUW); ignored when XLEN=32.
REQ-009 req_rs1, req_rs2  in  XLEN each  operands a and b.
REQ-010 req_rsd_idx  in  RFIDX_W  destination index, returned unchanged with the result.
REQ-011 flush  in  1  aborts the operation in flight.
REQ-012 resp_valid  out  1  result available.
REQ-013 resp_ready  in  1  consumer accepts the result.
REQ-014 resp_data  out  XLEN  result.
REQ-015 resp_rsd_idx  out  RFIDX_W  destination index of the result.
REQ-016 busy  out  1  high in BUSY or DONE; drives the pipeline stall.

Function
REQ-017 FSM states SHALL be IDLE, BUSY and DONE.
REQ-018 IDLE->BUSY SHALL occur on req_valid & req_ready & ~flush; the block SHALL latch the operands, funct3, word and rsd_idx on that edge.
REQ-019 Multiplication SHALL be radix-2 shift-add over N iterations, one per cycle, with N=32 for W-ops or when XLEN=32, and N=XLEN otherwise.
REQ-020 Division SHALL be restoring radix-2 over magnitudes with N iterations, with the result sign fixed after the last iteration.
REQ-021 When BUSY has performed N iterations, the FSM SHALL go BUSY->DONE, so resp_valid rises N+1 edges after the acceptance edge.
REQ-022 Divide-by-zero SHALL take a fast path straight to DONE in 1 cycle, giving quotient all-ones and remainder equal to the dividend.
REQ-023 Signed overflow (most-negative / -1) SHALL take a fast path straight to DONE in 1 cycle, giving quotient equal to the dividend and remainder 0.
REQ-024 MUL SHALL return the low XLEN bits of the product.
REQ-025 MULH, MULHSU and MULHU SHALL return the high XLEN bits of the product, with operands signed/signed, signed/unsigned and unsigned/unsigned respectively.
REQ-026 W-ops SHALL use operand bits [31:0] only, and resp_data SHALL be the 32-bit result sign-extended to XLEN.
REQ-027 In DONE, resp_valid SHALL be 1, and resp_data and resp_rsd_idx SHALL hold stable until resp_ready is sampled high.
REQ-028 DONE->IDLE SHALL occur on resp_ready; no new request SHALL be accepted in that same cycle (req_ready is low in DONE).
REQ-029 Flush in BUSY or DONE SHALL return the FSM to IDLE on the next edge, and no response SHALL be issued for the aborted operation.
REQ-030 Flush in IDLE SHALL block acceptance in that cycle.
REQ-031 Flush SHALL take priority over every other transition.
REQ-032 req_valid with req_ready low SHALL be ignored, and the requester SHALL hold the request until it is accepted.

Reset
REQ-033 On rst_n low, the FSM SHALL enter IDLE asynchronously.
REQ-034 On rst_n low, the outputs SHALL be: req_ready=1, resp_valid=0, busy=0, resp_data=0, resp_rsd_idx=0, and the iteration counter 0.
REQ-035 Reset asserted mid-operation SHALL discard the operation, and no response SHALL be issued after reset is released.

Verification
REQ-036 MUL, XLEN=64: a=-3, b=7, rsd=5 -> resp_valid at edge 65 after acceptance, resp_data=0xFFFFFFFFFFFFFFEB, resp_rsd_idx=5.
REQ-037 MULHU: a=b=0xFFFFFFFFFFFFFFFF -> resp_data=0xFFFFFFFFFFFFFFFE. MULH with the same operands -> 0.
REQ-038 DIV: a=-7, b=2 -> quotient -3. REM with the same operands -> remainder -1. DIVW: a=0x00000000_80000000, b=0xFFFFFFFF -> resp_data=0xFFFFFFFF80000000 in 1 cycle (overflow fast path).
REQ-039 DIVU: b=0, a=42 -> resp_valid 1 cycle after acceptance, resp_data all-ones. REMU with the same operands -> 42.
REQ-040 Hold resp_ready=0 for 10 cycles in DONE -> resp_valid, resp_data and busy stay stable, and req_ready stays 0 throughout.
REQ-041 Assert flush at iteration 20 of a DIV -> IDLE next edge, resp_valid never rises, and a following MUL completes correctly; reset asserted mid-BUSY -> IDLE immediately, with all outputs at their reset values.
